// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and constants for the alarm ring controller.
// State encoding, BCD digit widths and default timing parameters.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ARMED  = 2'b01,
        RING   = 2'b10,
        SNOOZE = 2'b11
    } alarm_state_t;

    localparam int H_TENS_W  = 2;
    localparam int H_UNITS_W = 4;
    localparam int M_TENS_W  = 3;
    localparam int M_UNITS_W = 4;
    localparam int SEC_W     = 6;

    localparam int RING_SECS_DEF   = 60;
    localparam int SNOOZE_SECS_DEF = 300;
    localparam int MAX_SNOOZE_DEF  = 3;

endpackage

// File: rtl/alarm_ring_ctrl_sec_down_counter.sv
// sec_down_counter: saturating seconds down-counter with load.
// Load wins over a coincident tick; the count never wraps below 0.
module sec_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         sec_tick,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Count register: load, else decrement on tick until zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (sec_tick && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: arm / ring / snooze / dismiss sequencer.
// Snooze support is compiled in only when ALARM_SNOOZE_EN is defined.
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
`ifdef ALARM_SNOOZE_EN
    parameter int SNOOZE_SECS = SNOOZE_SECS_DEF,
    parameter int MAX_SNOOZE  = MAX_SNOOZE_DEF,
`endif
    parameter int RING_SECS   = RING_SECS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sec_tick,
    input  logic [H_TENS_W-1:0]  wi_1,
    input  logic [H_UNITS_W-1:0] wi_2,
    input  logic [M_TENS_W-1:0]  wi_3,
    input  logic [M_UNITS_W-1:0] wi_4,
    input  logic [SEC_W-1:0]     seconds,
    input  logic [H_TENS_W-1:0]  ai_1,
    input  logic [H_UNITS_W-1:0] ai_2,
    input  logic [M_TENS_W-1:0]  ai_3,
    input  logic [M_UNITS_W-1:0] ai_4,
    input  logic                 arm_req,
    input  logic                 disarm_req,
    input  logic                 snooze_btn,
    input  logic                 dismiss_btn,
    output logic                 armed,
    output logic                 ringing,
    output logic                 led_blink,
    output logic                 snooze_active,
    output logic [2:0]           snooze_left
);

    alarm_state_t state, next_state;

    logic match, match_q, hit;
    logic ring_load, ring_tick, ring_zero, ring_exp;
    logic ring_dismiss;
    logic armed_n, ringing_n, led_n;

    assign match = (wi_1 == ai_1) && (wi_2 == ai_2) &&
                   (wi_3 == ai_3) && (wi_4 == ai_4) &&
                   (seconds == '0);
    assign hit = match && !match_q;

    // Counters hold "ticks left minus one", so expiry is the tick
    // that arrives while the count already sits at zero.
    assign ring_load = (next_state == RING) && (state != RING);
    assign ring_tick = sec_tick && (state == RING);
    assign ring_exp  = ring_tick && ring_zero;

    sec_down_counter #(.W(8)) u_ring_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (ring_load),
        .load_val (8'(RING_SECS - 1)),
        .sec_tick (ring_tick),
        .zero     (ring_zero)
    );

`ifdef ALARM_SNOOZE_EN
    logic snooze_load, snooze_tick, snooze_zero, snooze_exp;
    logic snooze_go, no_snooze;
    logic snooze_active_n;
    logic [2:0] left_n;

    assign snooze_load = (next_state == SNOOZE) && (state != SNOOZE);
    assign snooze_tick = sec_tick && (state == SNOOZE);
    assign snooze_exp  = snooze_tick && snooze_zero;

    assign no_snooze    = (snooze_left == 3'd0);
    assign snooze_go    = snooze_btn && !no_snooze;
    assign ring_dismiss = dismiss_btn || (snooze_btn && no_snooze);

    sec_down_counter #(.W(9)) u_snooze_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (snooze_load),
        .load_val (9'(SNOOZE_SECS - 1)),
        .sec_tick (snooze_tick),
        .zero     (snooze_zero)
    );
`else
    assign ring_dismiss  = dismiss_btn || snooze_btn;
    assign snooze_active = 1'b0;
    assign snooze_left   = 3'd0;
`endif

    // State, match history and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            match_q       <= 1'b0;
            armed         <= 1'b0;
            ringing       <= 1'b0;
            led_blink     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_active <= 1'b0;
            snooze_left   <= 3'(MAX_SNOOZE);
`endif
        end else begin
            state         <= next_state;
            match_q       <= match;
            armed         <= armed_n;
            ringing       <= ringing_n;
            led_blink     <= led_n;
`ifdef ALARM_SNOOZE_EN
            snooze_active <= snooze_active_n;
            snooze_left   <= left_n;
`endif
        end
    end

    // Next state, priority: disarm > arm > dismiss > snooze > expiry > hit.
    always_comb begin
        next_state = state;
        if (disarm_req) begin
            next_state = IDLE;
        end else if (arm_req) begin
            next_state = ARMED;
        end else begin
            unique case (state)
                IDLE:  next_state = IDLE;
                ARMED: if (hit) next_state = RING;
                RING: begin
                    if (ring_dismiss)   next_state = ARMED;
`ifdef ALARM_SNOOZE_EN
                    else if (snooze_go) next_state = SNOOZE;
`endif
                    else if (ring_exp)  next_state = ARMED;
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (dismiss_btn)     next_state = ARMED;
                    else if (snooze_exp) next_state = RING;
                end
`endif
                default: next_state = IDLE;
            endcase
        end
    end

    // Output values for the state being entered on this edge.
    always_comb begin
        armed_n   = (next_state != IDLE);
        ringing_n = (next_state == RING);
        led_n     = 1'b0;
        if (next_state == RING) begin
            if (ring_load)      led_n = 1'b1;
            else if (ring_tick) led_n = !led_blink;
            else                led_n = led_blink;
        end
`ifdef ALARM_SNOOZE_EN
        snooze_active_n = (next_state == SNOOZE);
        left_n          = snooze_left;
        if (next_state == IDLE || next_state == ARMED)
            left_n = 3'(MAX_SNOOZE);
        else if (snooze_load)
            left_n = snooze_left - 3'd1;
`endif
    end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl: directed vector table plus multi-cycle sequences.
// Snooze sequences are included when ALARM_SNOOZE_EN is defined.
`timescale 1ns/1ps
module tb_alarm_ring_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sec_tick = 1'b0;
    logic [1:0] wi_1 = '0;
    logic [3:0] wi_2 = '0;
    logic [2:0] wi_3 = '0;
    logic [3:0] wi_4 = '0;
    logic [5:0] seconds = '0;
    logic [1:0] ai_1 = 2'd0;
    logic [3:0] ai_2 = 4'd7;
    logic [2:0] ai_3 = 3'd0;
    logic [3:0] ai_4 = 4'd0;
    logic       arm_req = 1'b0;
    logic       disarm_req = 1'b0;
    logic       snooze_btn = 1'b0;
    logic       dismiss_btn = 1'b0;
    logic       armed, ringing, led_blink, snooze_active;
    logic [2:0] snooze_left;

`ifdef ALARM_SNOOZE_EN
    localparam logic [2:0] SL = 3'd3;
`else
    localparam logic [2:0] SL = 3'd0;
`endif

    int tests = 0;
    int fails = 0;

    alarm_ring_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .sec_tick      (sec_tick),
        .wi_1          (wi_1),
        .wi_2          (wi_2),
        .wi_3          (wi_3),
        .wi_4          (wi_4),
        .seconds       (seconds),
        .ai_1          (ai_1),
        .ai_2          (ai_2),
        .ai_3          (ai_3),
        .ai_4          (ai_4),
        .arm_req       (arm_req),
        .disarm_req    (disarm_req),
        .snooze_btn    (snooze_btn),
        .dismiss_btn   (dismiss_btn),
        .armed         (armed),
        .ringing       (ringing),
        .led_blink     (led_blink),
        .snooze_active (snooze_active),
        .snooze_left   (snooze_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       mt;
        logic       arm;
        logic       disarm;
        logic       dismiss;
        logic       tick;
        logic [3:0] exp;
    } vec_t;

    localparam int NV = 27;
    vec_t vt [NV];

    function automatic logic [6:0] obs();
        return {armed, ringing, led_blink, snooze_active, snooze_left};
    endfunction

    task automatic chk(input string nm, input logic [6:0] act,
                       input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Clock 07:00:00 matches alarm 07:00; 06:59:59 does not.
    task automatic set_match(input logic m);
        if (m) begin
            wi_1 = 2'd0; wi_2 = 4'd7; wi_3 = 3'd0; wi_4 = 4'd0;
            seconds = 6'd0;
        end else begin
            wi_1 = 2'd0; wi_2 = 4'd6; wi_3 = 3'd5; wi_4 = 4'd9;
            seconds = 6'd59;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        arm_req = 0; disarm_req = 0; snooze_btn = 0;
        dismiss_btn = 0; sec_tick = 0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            sec_tick = 1; cyc(); sec_tick = 0; cyc();
        end
    endtask

    initial begin
        int rises;
        int hi;
        logic prev;

        //          rst  mt   arm  dis  dsm  tick  armed,ring,led,sa
        vt[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000};
        vt[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'b0000};
        vt[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,4'b1000};
        vt[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'b1000};
        vt[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'b1000};
        vt[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,4'b1110};
        vt[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,4'b1100};
        vt[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'b1100};
        vt[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,4'b1110};
        vt[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,4'b1000};
        vt[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'b1000};
        vt[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'b1000};
        vt[12] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'b1110};
        vt[13] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,4'b0000};
        vt[14] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,4'b1000};
        vt[15] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,4'b1000};
        vt[16] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'b1000};
        vt[17] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'b1000};
        vt[18] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'b1110};
        vt[19] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,4'b1000};
        vt[20] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,4'b0000};
        vt[21] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'b0000};
        vt[22] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,4'b1000};
        vt[23] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'b1110};
        vt[24] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'b0000};
        vt[25] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'b0000};
        vt[26] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000};

        for (int i = 0; i < NV; i++) begin
            rst = vt[i].rst;
            set_match(vt[i].mt);
            arm_req = vt[i].arm;
            disarm_req = vt[i].disarm;
            dismiss_btn = vt[i].dismiss;
            sec_tick = vt[i].tick;
            cyc();
            chk($sformatf("vec%0d", i), obs(), {vt[i].exp, SL});
        end
        clr();

        // Full ring: entry, 60 ticks with LED toggling, auto stop.
        set_match(0); arm_req = 1; cyc(); clr();
        sec_tick = 1; cyc(); clr();
        set_match(1); cyc();
        chk("ring_entry", obs(), {4'b1110, SL});
        set_match(0);
        for (int k = 1; k <= 60; k++) begin
            sec_tick = 1; cyc(); sec_tick = 0;
            chk($sformatf("ring_tick%0d", k), obs(),
                {1'b1, k < 60, (k < 60) && (k % 2 == 0), 1'b0, SL});
            cyc();
        end

        // Held match: one ring entry only; no re-trigger after dismiss.
        rises = 0; prev = ringing;
        set_match(1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (ringing && !prev) rises++;
            prev = ringing;
        end
        tests++;
        if (rises != 1) begin
            fails++;
            $display("FAIL held_match_rises: got %0d expected 1", rises);
        end
        dismiss_btn = 1; cyc(); clr();
        chk("held_dismiss", obs(), {4'b1000, SL});
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (ringing) hi++;
        end
        tests++;
        if (hi != 0) begin
            fails++;
            $display("FAIL held_retrigger: got %0d expected 0", hi);
        end
        set_match(0); cyc();

`ifdef ALARM_SNOOZE_EN
        // Three snoozes of 300 s each, then the 4th press dismisses.
        set_match(1); cyc();
        chk("sz_ring", obs(), 7'b1110011);
        for (int n = 1; n <= 3; n++) begin
            snooze_btn = 1; cyc(); clr();
            chk($sformatf("sz%0d_enter", n), obs(),
                {4'b1001, 3'(3 - n)});
            tick_n(299);
            chk($sformatf("sz%0d_299", n), obs(),
                {4'b1001, 3'(3 - n)});
            sec_tick = 1; cyc(); clr();
            chk($sformatf("sz%0d_ring", n), obs(),
                {4'b1110, 3'(3 - n)});
        end
        snooze_btn = 1; cyc(); clr();
        chk("sz4_dismiss", obs(), 7'b1000011);
        set_match(0); cyc();

        // Dismiss and snooze together: dismiss wins.
        set_match(1); cyc();
        dismiss_btn = 1; snooze_btn = 1; cyc(); clr();
        chk("dsm_and_sz", obs(), 7'b1000011);
        set_match(0); cyc();

        // Reset mid-snooze, then no ring until re-armed.
        set_match(1); cyc();
        snooze_btn = 1; cyc(); clr();
        set_match(0);
        tick_n(149);
        chk("rst_pre", obs(), 7'b1001010);
        rst = 0; cyc(); rst = 1;
        chk("rst_mid_sz", obs(), 7'b0000011);
        set_match(1); cyc();
        chk("rst_no_ring", obs(), 7'b0000011);
        arm_req = 1; cyc(); clr();
        set_match(0); cyc();
        set_match(1); cyc();
        chk("rst_rearm_ring", obs(), 7'b1110011);
        set_match(0);
`else
        // Snooze button without snooze support behaves as dismiss.
        set_match(1); cyc();
        chk("nsz_ring", obs(), 7'b1110000);
        snooze_btn = 1; cyc(); clr();
        chk("nsz_snooze_dismiss", obs(), 7'b1000000);
        set_match(0); cyc();
        chk("nsz_hold", obs(), 7'b1000000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
